// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width default for the serial adder
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_bh.sv
// rtl/full_adder_bh.sv - behavioural 1-bit full adder
module full_adder_bh (
   output logic s,
   output logic c,
   input  logic a,
   input  logic b,
   input  logic cin
);

   // sum and majority carry of the three input bits
   always_comb begin
      s = a ^ b ^ cin;
      c = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, LSB first, one bit per cycle
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             s_bit;
   logic             c_bit;
   logic             accept;
   logic             last_bit;

   // DONE accepts a new start just like IDLE; RUN never does
   assign accept   = start && (state_q != RUN);
   assign last_bit = (cnt == CNT_LAST);

   full_adder_bh u_fa (
      .s   (s_bit),
      .c   (c_bit),
      .a   (a_reg[cnt]),
      .b   (b_reg[cnt]),
      .cin (carry_q)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and status outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // operand capture, bit-serial accumulation and result publication
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_reg   <= a;
         b_reg   <= b;
         carry_q <= cin;
         cnt     <= '0;
      end else if (state_q == RUN) begin
         // result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
         acc     <= {s_bit, acc[WIDTH-1:1]};
         carry_q <= c_bit;
         cnt     <= cnt + CW'(1);
         if (last_bit) begin
            sum  <= {s_bit, acc[WIDTH-1:1]};
            cout <= c_bit;
            ovf  <= carry_q ^ c_bit;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl at WIDTH=8
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_pass;
   int n_total;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: unsigned sum modulo 2^W with carry, signed range check for overflow
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      res_t r;
      int   u;
      int   s;
      u = int'(x) + int'(y) + int'(ci);
      s = int'($signed(x)) + int'($signed(y)) + int'(ci);
      r.sum  = u[W-1:0];
      r.cout = (u >= (1 << W));
      r.ovf  = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // starts one addition from a negedge with the DUT idle and watches it to completion
   task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input int poke_cyc, output res_t r, output int lat,
                         output int busy_n, output int done_n, output int stable);
      logic [W-1:0] prev;
      bit           got;
      prev   = sum;
      r      = '{sum: '0, cout: 1'b0, ovf: 1'b0};
      lat    = -1;
      busy_n = 0;
      done_n = 0;
      stable = 1;
      got    = 0;
      a = ai; b = bi; cin = ci; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      for (int i = 1; i <= W + 6; i++) begin
         @(negedge clk);
         if (i == poke_cyc) begin
            start = 1'b1; a = 8'hAA; b = 8'h55;
         end else begin
            start = 1'b0;
         end
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (!got) begin
               got = 1; lat = i - 1;
               r.sum = sum; r.cout = cout; r.ovf = ovf;
            end
         end
         if (!got && sum != prev) stable = 0;
      end
   endtask

   vec_t tbl[5];
   res_t r;
   res_t e;
   int   lat, busy_n, done_n, stable;
   int   bad_done, bad_sum, n_done, seen;
   logic [W-1:0] last_sum;
   res_t exp_q[$];

   initial begin
      n_pass = 0; n_total = 0;
      tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
      tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
      tbl[2] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
      tbl[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
      tbl[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_sum", int'(sum), 0);
      chk("reset_cout", int'(cout), 0);
      chk("reset_ovf", int'(ovf), 0);
      rst = 1'b0;

      // directed vectors; the first starts right after reset release
      for (int k = 0; k < 5; k++) begin
         run_op(tbl[k].a, tbl[k].b, tbl[k].cin, 0, r, lat, busy_n, done_n, stable);
         chk($sformatf("vec%0d_sum", k), int'(r.sum), int'(tbl[k].sum));
         chk($sformatf("vec%0d_cout", k), int'(r.cout), int'(tbl[k].cout));
         chk($sformatf("vec%0d_ovf", k), int'(r.ovf), int'(tbl[k].ovf));
         chk($sformatf("vec%0d_latency", k), lat, W);
         chk($sformatf("vec%0d_busy_cycles", k), busy_n, W);
         chk($sformatf("vec%0d_done_pulses", k), done_n, 1);
         chk($sformatf("vec%0d_sum_stable", k), stable, 1);
      end

      // start during RUN must be ignored
      e = model(8'h12, 8'h34, 1'b1);
      run_op(8'h12, 8'h34, 1'b1, 3, r, lat, busy_n, done_n, stable);
      chk("poke_sum", int'(r.sum), int'(e.sum));
      chk("poke_cout", int'(r.cout), int'(e.cout));
      chk("poke_done_pulses", done_n, 1);
      chk("poke_latency", lat, W);

      // reset in the middle of RUN aborts with no done pulse
      a = 8'h3C; b = 8'h21; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_sum", int'(sum), 0);
      chk("midrst_cout", int'(cout), 0);
      chk("midrst_ovf", int'(ovf), 0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      chk("midrst_no_activity", n_done, 0);
      e = model(8'hC3, 8'h5A, 1'b1);
      run_op(8'hC3, 8'h5A, 1'b1, 0, r, lat, busy_n, done_n, stable);
      chk("after_rst_sum", int'(r.sum), int'(e.sum));
      chk("after_rst_cout", int'(r.cout), int'(e.cout));
      chk("after_rst_ovf", int'(r.ovf), int'(e.ovf));

      // random operands against the model
      for (int k = 0; k < 24; k++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         e = model(ra, rb, rc);
         run_op(ra, rb, rc, 0, r, lat, busy_n, done_n, stable);
         chk($sformatf("rnd%0d_sum a=%0h b=%0h c=%0d", k, ra, rb, rc), int'(r.sum), int'(e.sum));
         chk($sformatf("rnd%0d_cout", k), int'(r.cout), int'(e.cout));
         chk($sformatf("rnd%0d_ovf", k), int'(r.ovf), int'(e.ovf));
         chk($sformatf("rnd%0d_done_pulses", k), done_n, 1);
      end

      // start held high: accepts every W+1 cycles, operands wiggle in between
      @(negedge clk);
      bad_done = 0; bad_sum = 0; seen = 0;
      last_sum = sum;
      start = 1'b1;
      for (int n = 0; n <= 6 * (W + 1); n++) begin
         if (n > 0) begin
            if (n % (W + 1) == 0) begin
               if (!done) bad_done++;
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  seen++;
                  chk($sformatf("b2b%0d_sum", seen), int'(sum), int'(e.sum));
                  chk($sformatf("b2b%0d_cout", seen), int'(cout), int'(e.cout));
                  chk($sformatf("b2b%0d_ovf", seen), int'(ovf), int'(e.ovf));
               end
               last_sum = sum;
            end else begin
               if (done) bad_done++;
               if (sum != last_sum) bad_sum++;
            end
         end
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         if (n % (W + 1) == 0) exp_q.push_back(model(a, b, cin));
         @(negedge clk);
      end
      start = 1'b0;
      chk("b2b_done_timing_errors", bad_done, 0);
      chk("b2b_sum_stability_errors", bad_sum, 0);
      chk("b2b_results_seen", seen, 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request one addition; sampled only at clk rising edges.
REQ-006 a  input  WIDTH  operand A, captured on accepted start.
REQ-007 b  input  WIDTH  operand B, captured on accepted start.
REQ-008 cin  input  1  carry-in, captured on accepted start.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse marking a new valid result.
REQ-011 sum  output  WIDTH  registered result of the last completed addition.
REQ-012 cout  output  1  carry out of bit WIDTH-1 for the last completed addition.
REQ-013 ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB) for the last completed addition.

Function
REQ-014 The block SHALL compute a + b + cin bit-serially, LSB first, one bit per clk cycle, through a single 1-bit full-adder datapath.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE: start=1 SHALL load a, b and cin into internal registers, clear the bit counter and go to RUN; start=0 SHALL stay in IDLE.
REQ-017 RUN: each edge SHALL add operand bit[cnt] with the carry register, store the sum bit, update the carry register and increment cnt.
REQ-018 RUN: on the edge that processes cnt==WIDTH-1, the FSM SHALL go to DONE and update sum, cout and ovf in the same edge.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE; start=1 while in DONE SHALL be accepted like in IDLE, going directly to RUN.
REQ-020 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-021 Latency: done SHALL go high WIDTH cycles after the accepting edge, giving WIDTH+1 cycles start-to-start for back-to-back operation.
REQ-022 start while in RUN SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-023 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-024 sum, cout and ovf SHALL hold their previous values during RUN and change only on the RUN->DONE edge.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout.
REQ-026 ovf SHALL equal the XOR of the carry into bit WIDTH-1 and the carry out of bit WIDTH-1.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, cnt 0, carry register 0, busy 0, done 0, sum 0, cout 0, ovf 0.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse, and the operand registers SHALL be treated as don't-care.
REQ-029 start SHALL be honoured from the first rising edge after rst deasserts.

Structure
REQ-030 Shared package serial_adder_pkg SHALL hold the state encoding constants (IDLE=0, RUN=1, DONE=2, 2 bits) and the WIDTH default.
REQ-031 The 1-bit datapath SHALL be the existing full_adder_bh instantiated once, with ports in the order (s, c, a, b, cin).
REQ-032 The bit counter SHALL be $clog2(WIDTH) bits wide, and the carry register and shift/result registers SHALL live in serial_adder_ctrl.

Verification (WIDTH=8)
REQ-033 start with a=0x0F, b=0x01, cin=0 -> done high 8 cycles later, sum=0x10, cout=0, ovf=0, busy high for 8 cycles.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-035 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
REQ-036 start pulsed again at RUN cycle 3 with a=0xAA, b=0x55 -> ignored; the original result completes unchanged and exactly one done pulse occurs.
REQ-037 rst asserted at RUN cycle 4 -> busy, done, sum and cout read 0 immediately, no done pulse follows, and a fresh start afterwards completes correctly.
REQ-038 start held high continuously with new operands -> done pulses every 9 cycles, each result matches its operands, and sum is stable between pulses.
